// File: rtl/hash_out_serializer_pkg.sv
// ============================================================================
// Module : hash_out_serializer_pkg
// Brief  : Shared sizing constants and FSM encoding for the hash serializer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hash_out_serializer_pkg;

    localparam int DEF_DATA_W  = 3072;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_CNT_W   = 7;
    localparam int FRAME_CNT_W = 16;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hash_out_serializer_rise_detect.sv
// ============================================================================
// Module : hash_out_serializer_rise_detect
// Brief  : Registered 1-bit rising-edge detector, asynchronous active-high reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hash_out_serializer_rise_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb din_d = din;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

`default_nettype wire

// File: rtl/hash_out_serializer.sv
// ============================================================================
// Module : hash_out_serializer
// Brief  : Captures the wide hash result and streams it MSB-word first over
//          valid/ready, with a one-frame shadow buffer behind the shift reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hash_out_serializer
    import hash_out_serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      final_result,
    input  logic                   write_en,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int               NUM_WORDS = DATA_W / WORD_W;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);

    logic                   cap;
    logic                   xfer;
    logic                   last_xfer;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       idx_q,       idx_d;
    logic [DATA_W-1:0]      shreg_q,     shreg_d;
    logic [DATA_W-1:0]      shadow_q,    shadow_d;
    logic                   pending_q,   pending_d;
    logic                   overflow_q,  overflow_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    hash_out_serializer_rise_detect u_cap_detect (
        .clk_in (clk_in),
        .rst    (rst),
        .din    (write_en),
        .rise   (cap)
    );

    assign xfer      = (state_q == ST_SEND) & out_ready;
    assign last_xfer = xfer & (idx_q == LAST_IDX);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cap) state_d = ST_SEND;
            ST_SEND: if (last_xfer && !pending_q && !cap) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        if (state_q == ST_IDLE) begin
            if (cap) begin
                shreg_d = final_result;
                idx_d   = '0;
            end
        end else if (last_xfer) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            idx_d       = '0;
            // The shadow frame goes first; a coincident capture then refills the freed shadow.
            if (pending_q) begin
                shreg_d   = shadow_q;
                pending_d = cap;
                if (cap) shadow_d = final_result;
            end else if (cap) begin
                shreg_d = final_result;
            end else begin
                shreg_d = shreg_q << WORD_W;
            end
        end else begin
            if (xfer) begin
                shreg_d = shreg_q << WORD_W;
                idx_d   = idx_q + CNT_W'(1);
            end
            if (cap) begin
                if (pending_q) begin
                    overflow_d = 1'b1;
                end else begin
                    shadow_d  = final_result;
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        busy      = (state_q == ST_SEND);
        out_data  = shreg_q[DATA_W-1 -: WORD_W];
        out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
        overflow  = overflow_q;
        frame_cnt = frame_cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_hash_out_serializer.sv
// ============================================================================
// Module : tb_hash_out_serializer
// Brief  : Directed/random bench against a frame-queue reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hash_out_serializer;

    localparam int DW = 3072;
    localparam int NW = 96;

    logic           clk_in = 1'b0;
    logic           rst;
    logic [DW-1:0]  final_result;
    logic           write_en;
    logic           out_ready;
    logic [31:0]    out_data;
    logic           out_valid;
    logic           out_last;
    logic           busy;
    logic           overflow;
    logic [15:0]    frame_cnt;

    hash_out_serializer dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .final_result (final_result),
        .write_en     (write_en),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .busy         (busy),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt)
    );

    initial forever #5 clk_in = ~clk_in;

    // Reference model: queue of accepted frames (at most current + one waiting).
    logic [DW-1:0] m_frames[$];
    int            m_idx;
    logic [15:0]   m_fcnt;
    logic          m_ovf;
    logic          m_we_prev;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat_frame();
        logic [DW-1:0] f;
        for (int i = 0; i < NW; i++) f[DW-1-32*i -: 32] = 32'hA5A5_0000 + 32'(i);
        return f;
    endfunction

    function automatic logic [DW-1:0] rnd_frame();
        logic [DW-1:0] f;
        for (int i = 0; i < NW; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        m_frames.delete();
        m_idx     = 0;
        m_fcnt    = 16'd0;
        m_ovf     = 1'b0;
        m_we_prev = 1'b0;
    endtask

    // Check outputs at the falling edge, then advance the model with this cycle's inputs.
    task automatic step();
        logic [DW-1:0] head;
        logic          exp_v;
        logic          cap;
        logic          xfer;
        @(negedge clk_in);
        exp_v = (m_frames.size() > 0);
        chk("valid", 32'(out_valid), 32'(exp_v));
        chk("busy", 32'(busy), 32'(exp_v));
        chk("last", 32'(out_last), 32'(exp_v && m_idx == NW-1));
        if (exp_v) begin
            head = m_frames[0];
            chk("data", out_data, head[DW-1-32*m_idx -: 32]);
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));

        cap       = write_en & ~m_we_prev;
        m_we_prev = write_en;
        xfer      = exp_v & out_ready;
        if (xfer) begin
            if (m_idx == NW-1) begin
                void'(m_frames.pop_front());
                m_idx  = 0;
                m_fcnt = m_fcnt + 16'd1;
            end else begin
                m_idx++;
            end
        end
        if (cap) begin
            if (m_frames.size() < 2) m_frames.push_back(final_result);
            else m_ovf = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_ready(input int pct);
        out_ready = ($urandom_range(0, 99) < pct);
    endtask

    task automatic pulse(input logic [DW-1:0] f, input int pct);
        final_result = f;
        write_en     = 1'b1;
        set_ready(pct);
        step();
        set_ready(pct);
        step();
        write_en = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input int pct);
        int n = 0;
        while (m_frames.size() > 0 && n < max_cycles) begin
            set_ready(pct);
            step();
            n++;
        end
        chk("drain_done", 32'(m_frames.size()), 32'd0);
        step();
    endtask

    task automatic wait_idx(input int target, input int pct);
        int n = 0;
        while (!(m_frames.size() > 0 && m_idx == target) && n < 500) begin
            set_ready(pct);
            step();
            n++;
        end
        chk("wait_idx", 32'(m_idx), 32'(target));
    endtask

    initial begin
        rst          = 1'b1;
        write_en     = 1'b0;
        out_ready    = 1'b0;
        final_result = '0;
        model_reset();
        #12;
        chk("rst_data", out_data, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        step();

        // 1: counting pattern, full throughput
        pulse(pat_frame(), 100);
        drain(300, 100);
        chk("t1_fcnt", 32'(frame_cnt), 32'd1);

        // 2: random data under heavy backpressure
        pulse(rnd_frame(), 30);
        drain(2000, 30);
        chk("t2_fcnt", 32'(frame_cnt), 32'd2);

        // 3: second capture mid-frame goes through the shadow
        pulse(rnd_frame(), 100);
        wait_idx(40, 100);
        pulse(rnd_frame(), 100);
        drain(400, 100);
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_fcnt", 32'(frame_cnt), 32'd4);

        // 4: third capture while shadow full is dropped
        pulse(rnd_frame(), 100);
        wait_idx(10, 100);
        pulse(rnd_frame(), 100);
        wait_idx(20, 100);
        pulse(rnd_frame(), 100);
        drain(400, 100);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_fcnt", 32'(frame_cnt), 32'd6);

        // 5: capture coincident with last-word transfer
        pulse(rnd_frame(), 100);
        wait_idx(NW-1, 100);
        pulse(rnd_frame(), 100);
        chk("t5_valid_kept", 32'(out_valid), 32'd1);
        drain(400, 100);
        chk("t5_fcnt", 32'(frame_cnt), 32'd8);

        // 6: asynchronous reset mid-frame, then restart
        pulse(rnd_frame(), 100);
        wait_idx(50, 100);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_data", out_data, 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_last", 32'(out_last), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_fcnt", 32'(frame_cnt), 32'd0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        step();
        pulse(rnd_frame(), 50);
        drain(1000, 50);
        chk("t6_fcnt_after", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
